// File: rtl/uart_reg_responder_if.sv
// Handshake and register-bus bundle between the UART reader/writer pair,
// the register responder and the firmware control register file.
interface uart_reg_responder_if;
  logic       rx_valid;
  logic [7:0] rx_q;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       cmd_err;

  // Responder side: consumes rx bytes and read data, drives tx and bus strobes.
  modport master (
    input  rx_valid, rx_q, tx_busy, reg_rdata,
    output tx_din, tx_wr_en, reg_addr, reg_wdata, reg_we, reg_re, cmd_err
  );

  // Environment side: UART PHY pair plus register file.
  modport slave (
    output rx_valid, rx_q, tx_busy, reg_rdata,
    input  tx_din, tx_wr_en, reg_addr, reg_wdata, reg_we, reg_re, cmd_err
  );
endinterface

// File: rtl/uart_reg_responder.sv
// UART register-access responder: decodes 0x57 addr data (write) and
// 0x52 addr (read) commands, performs one register access and returns a
// single response byte (ACK, read data or NAK).
module uart_reg_responder #(
  parameter int                     TIMEOUT_BIT = 24,
  parameter logic [TIMEOUT_BIT-1:0] TIMEOUT_CYC = 24'd5_000_000,
  parameter int                     RD_LAT      = 2
) (
  input logic                 CLK,
  input logic                 RST,
  uart_reg_responder_if.master bus
);

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [2:0] RD_LAT_L = 3'(RD_LAT);
  localparam logic [TIMEOUT_BIT-1:0] TO_ONE = {{(TIMEOUT_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    GET_ADDR   = 4'd1,
    GET_DATA   = 4'd2,
    BUS_WR     = 4'd3,
    BUS_RD     = 4'd4,
    RD_WAIT    = 4'd5,
    TX_REQ     = 4'd6,
    TX_WAIT_HI = 4'd7,
    TX_WAIT_LO = 4'd8
  } state_t;

  state_t                 state_r, state_s;
  logic [7:0]             cmd_r, cmd_s;
  logic [7:0]             addr_r, addr_s;
  logic [7:0]             wdata_r, wdata_s;
  logic [7:0]             tx_din_r, tx_din_s;
  logic                   we_r, we_s;
  logic                   re_r, re_s;
  logic                   err_r, err_s;
  logic [2:0]             lat_r, lat_s;
  logic [2:0]             hi_r, hi_s;
  logic [TIMEOUT_BIT-1:0] to_r, to_s;
  logic                   tx_wr_en_s;

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      cmd_r    <= 8'h00;
      addr_r   <= 8'h00;
      wdata_r  <= 8'h00;
      tx_din_r <= 8'h00;
      we_r     <= 1'b0;
      re_r     <= 1'b0;
      err_r    <= 1'b0;
      lat_r    <= 3'd0;
      hi_r     <= 3'd0;
      to_r     <= '0;
    end else begin
      state_r  <= state_s;
      cmd_r    <= cmd_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      tx_din_r <= tx_din_s;
      we_r     <= we_s;
      re_r     <= re_s;
      err_r    <= err_s;
      lat_r    <= lat_s;
      hi_r     <= hi_s;
      to_r     <= to_s;
    end
  end

  // Next-state decode; strobes are set on the transition so they are high
  // exactly during the BUS_WR / BUS_RD cycle.
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    tx_din_s   = tx_din_r;
    we_s       = 1'b0;
    re_s       = 1'b0;
    err_s      = 1'b0;
    lat_s      = lat_r;
    hi_s       = hi_r;
    to_s       = '0;
    tx_wr_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.rx_valid) begin
          cmd_s = bus.rx_q;
          if (bus.rx_q == CMD_WR || bus.rx_q == CMD_RD) begin
            state_s = GET_ADDR;
          end else begin
            tx_din_s = RSP_NAK;
            err_s    = 1'b1;
            state_s  = TX_REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GET_ADDR: begin
        // An arriving byte beats a simultaneous timeout terminal count.
        if (bus.rx_valid) begin
          addr_s = bus.rx_q;
          if (cmd_r == CMD_WR) begin
            state_s = GET_DATA;
          end else begin
            re_s    = 1'b1;
            state_s = BUS_RD;
          end
        end else if (to_r == TIMEOUT_CYC) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          to_s = to_r + TO_ONE;
        end
      end
      GET_DATA: begin
        if (bus.rx_valid) begin
          wdata_s = bus.rx_q;
          we_s    = 1'b1;
          state_s = BUS_WR;
        end else if (to_r == TIMEOUT_CYC) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          to_s = to_r + TO_ONE;
        end
      end
      BUS_WR: begin
        tx_din_s = RSP_ACK;
        state_s  = TX_REQ;
      end
      BUS_RD: begin
        lat_s   = RD_LAT_L;
        state_s = RD_WAIT;
      end
      RD_WAIT: begin
        // Counter value 1 here is the cycle RD_LAT after reg_re.
        if (lat_r <= 3'd1) begin
          lat_s    = 3'd0;
          tx_din_s = bus.reg_rdata;
          state_s  = TX_REQ;
        end else begin
          lat_s = lat_r - 3'd1;
        end
      end
      TX_REQ: begin
        if (!bus.tx_busy) begin
          tx_wr_en_s = 1'b1;
          hi_s       = 3'd0;
          state_s    = TX_WAIT_HI;
        end else begin
          state_s = TX_REQ;
        end
      end
      TX_WAIT_HI: begin
        if (bus.tx_busy) begin
          state_s = TX_WAIT_LO;
        end else if (hi_r == 3'd3) begin
          state_s = TX_WAIT_LO;
        end else begin
          hi_s = hi_r + 3'd1;
        end
      end
      TX_WAIT_LO: begin
        if (!bus.tx_busy) begin
          state_s = IDLE;
        end else begin
          state_s = TX_WAIT_LO;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // The write strobe is gated by the live busy input so it can never
  // coincide with tx_busy; every other output comes straight from a register.
  assign bus.tx_din    = tx_din_r;
  assign bus.tx_wr_en  = tx_wr_en_s;
  assign bus.reg_addr  = addr_r;
  assign bus.reg_wdata = wdata_r;
  assign bus.reg_we    = we_r;
  assign bus.reg_re    = re_r;
  assign bus.cmd_err   = err_r;

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Register-access responder on the UART link.
- Consumes received bytes from uart_reader (valid/q), decodes a 2- or 3-byte command, and performs one register-bus write or read.
- Returns one response byte through the uart_writer handshake (din/wr_en/busy).
- Sits between the UART PHY pair and the firmware control register file.

Parameters:
- TIMEOUT_BIT, 24, width of the inter-byte timeout counter.
- TIMEOUT_CYC, 24'd5_000_000, idle cycles allowed between bytes of one command before it is aborted.
- RD_LAT, 2, cycles from reg_re to reg_rdata valid; legal range 1..7.

Ports:
- CLK, input, 1, system clock; the uart_reader/uart_writer pair runs on this same clock.
- RST, input, 1, reset, synchronous, active-high.
- rx_valid, input, 1, one-cycle strobe from uart_reader: rx_q holds a new byte.
- rx_q, input, 8, received byte.
- tx_din, output, 8, byte to uart_writer.
- tx_wr_en, output, 1, one-cycle write strobe to uart_writer.
- tx_busy, input, 1, uart_writer busy.
- reg_addr, output, 8, register address.
- reg_wdata, output, 8, write data.
- reg_we, output, 1, one-cycle write strobe.
- reg_re, output, 1, one-cycle read strobe.
- reg_rdata, input, 8, read data, valid RD_LAT cycles after reg_re.
- cmd_err, output, 1, one-cycle pulse on bad command byte or timeout.

Behaviour:
- Reset: all outputs are 0, state is IDLE, timeout counter is 0. Reset mid-operation aborts immediately; no tx_wr_en or reg strobe is issued after reset.
- Protocol, write command: bytes 0x57, addr, data. Response is 0x06 (ACK).
- Protocol, read command: bytes 0x52, addr. Response is the read data byte.
- Protocol, any other first byte: response is 0x15 (NAK), cmd_err pulses, state returns to IDLE after the NAK is sent.
- State IDLE: on rx_valid, latch rx_q as the command byte.
  - 0x57 or 0x52 -> GET_ADDR.
  - Any other value -> TX_REQ with tx_din = 0x15.
- State GET_ADDR: on rx_valid, latch rx_q into reg_addr.
  - Write command -> GET_DATA.
  - Read command -> BUS_RD.
- State GET_DATA: on rx_valid, latch rx_q into reg_wdata -> BUS_WR.
- State BUS_WR: reg_we = 1 for exactly one cycle, tx_din = 0x06 -> TX_REQ.
- State BUS_RD: reg_re = 1 for exactly one cycle; load the latency counter with RD_LAT -> RD_WAIT.
- State RD_WAIT: decrement the latency counter; when it reaches 0, capture reg_rdata into tx_din -> TX_REQ.
  - Timing: tx_din equals reg_rdata sampled on the cycle RD_LAT after reg_re was high.
- State TX_REQ: when tx_busy = 0, assert tx_wr_en for one cycle -> TX_WAIT_HI. tx_din is held stable from entry to TX_REQ until TX_WAIT_LO exits.
- State TX_WAIT_HI: wait for tx_busy = 1 -> TX_WAIT_LO. If busy has not risen after 4 cycles, go to TX_WAIT_LO anyway.
- State TX_WAIT_LO: wait for tx_busy = 0 -> IDLE.
- Timeout:
  - Counter clears on every rx_valid and while in IDLE; it counts only in GET_ADDR and GET_DATA.
  - Reaching TIMEOUT_CYC -> cmd_err pulse, go to IDLE, no response byte, no bus strobe.
- Bytes arriving in any state other than IDLE/GET_ADDR/GET_DATA are dropped; they do not queue and do not raise cmd_err.
- Simultaneous events:
  - rx_valid on the same cycle as the timeout terminal count: the byte wins and the counter clears.
  - rx_valid in the same cycle that TX_WAIT_LO exits: the byte is dropped.
- Strobe rules: reg_we and reg_re are never high together; tx_wr_en is never asserted while tx_busy = 1.
- Throughput: one command in flight at a time; the host must wait for the response before sending the next command.

Test Plan:
- Write: send 0x57, 0x10, 0xAB -> one reg_we pulse with reg_addr = 0x10 and reg_wdata = 0xAB; then one tx_wr_en with tx_din = 0x06.
- Read, RD_LAT = 2: send 0x52, 0x22 with reg_rdata = 0x5C -> reg_re pulse with reg_addr = 0x22; tx_din = 0x5C with a single tx_wr_en; no reg_we.
- Bad command: send 0x41 -> cmd_err pulse, tx_din = 0x15 sent once, no bus strobe; then 0x52, 0x01 is served normally.
- Timeout, TIMEOUT_CYC = 1000: send 0x57, 0x05, then idle 1000 cycles -> cmd_err pulse, no reg_we, no tx_wr_en; then 0x52, 0x05 is served normally.
- Busy hold-off: hold tx_busy = 1 for 300 cycles before the response -> tx_wr_en fires only in the first cycle after busy falls; tx_din stays stable throughout; extra rx bytes received during that time are dropped.
- Reset mid-command: assert RST after 0x57, 0x10 -> all outputs 0; a later 0xAB byte is treated as a bad command (NAK 0x15, cmd_err).
